// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the counter family.
// Direction/mode encodings and the load clamp used by every counter block.
package cnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Out-of-range load values pin to the top of the count range.
    function automatic logic [31:0] clamp_ld(input logic [31:0] d, input logic [31:0] modulus);
        return (d > modulus - 32'd1) ? modulus - 32'd1 : d;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Free-running step prescaler: tick is high on the last of every PRESCALE enabled cycles.
// en=0 freezes the phase; clr restarts it from zero.
module cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] cnt;

    assign tick = (cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + PW'(1);
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, wrap/saturate mode and terminal-count pulse.
// Define UDCNT_PRESCALE_EN to step once per PRESCALE enabled clk cycles.
module updown_counter_param
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc
);

    generate
        if (WIDTH < 2 || MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_cfg
            $error("updown_counter_param: illegal WIDTH/MODULUS/PRESCALE");
        end
    endgenerate

    // One spare bit so MODULUS == 2**WIDTH still fits the limit constant.
    localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MODULUS - 1);

    logic             tick;
    logic             step;
    logic             at_limit;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;

`ifdef UDCNT_PRESCALE_EN
    cnt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (ld),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign q_ext    = {1'b0, q};
    assign step     = en & tick;
    assign at_limit = (up_dn == DIR_UP) ? (q_ext == MAXV) : (q_ext == '0);
    assign zero     = (q == '0);

    always_comb begin
        q_nxt  = q;
        tc_nxt = 1'b0;
        if (ld) begin
            q_nxt = WIDTH'(clamp_ld(32'(d), 32'(MODULUS)));
        end else if (step) begin
            tc_nxt = at_limit;
            if (up_dn == DIR_UP) begin
                if (!at_limit)
                    q_nxt = WIDTH'(q_ext + (WIDTH + 1)'(1));
                else if (sat == MODE_WRAP)
                    q_nxt = '0;
            end else begin
                if (!at_limit)
                    q_nxt = WIDTH'(q_ext - (WIDTH + 1)'(1));
                else if (sat == MODE_WRAP)
                    q_nxt = WIDTH'(MAXV);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            q  <= q_nxt;
            tc <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=4, MODULUS=10, PRESCALE=4): directed table,
// async reset, prescaler timing (under UDCNT_PRESCALE_EN) and random vs. a reference model.
module tb_updown_counter_param;

    localparam int WIDTH    = 4;
    localparam int MODULUS  = 10;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             en = 1'b0;
    logic             up_dn = 1'b0;
    logic             sat = 1'b0;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;

    int checks = 0;
    int errors = 0;

    updown_counter_param #(.WIDTH(WIDTH), .MODULUS(MODULUS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .en(en), .up_dn(up_dn), .sat(sat),
        .q(q), .zero(zero), .tc(tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] d;
        logic       en;
        logic       up_dn;
        logic       sat;
        int         exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int m_q, m_ecnt;
    logic m_tc;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int eq, input logic etc);
        check({name, ".q"}, int'(q), eq);
        check({name, ".tc"}, int'(tc), int'(etc));
        check({name, ".zero"}, int'(zero), int'(eq == 0));
    endtask

    // Drive at negedge, let one rising edge pass, sample 1 ns later.
    task automatic apply(input logic l, input logic [3:0] dv, input logic e, input logic u, input logic s);
        @(negedge clk);
        ld = l; d = dv; en = e; up_dn = u; sat = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic l, input int dv, input logic e, input logic u, input logic s,
                       input int eq, input logic etc);
        vec_t v;
        v.ld = l; v.d = 4'(dv); v.en = e; v.up_dn = u; v.sat = s; v.exp_q = eq; v.exp_tc = etc;
        tbl.push_back(v);
    endtask

    // Behavioural model: modular arithmetic straight from the counting rules.
    task automatic model_step(input logic l, input int dv, input logic e, input logic u, input logic s);
        int tick_now;
        m_tc = 1'b0;
        if (l) begin
            m_q    = (dv > MODULUS - 1) ? MODULUS - 1 : dv;
            m_ecnt = 0;
        end else if (e) begin
`ifdef UDCNT_PRESCALE_EN
            m_ecnt   = m_ecnt + 1;
            tick_now = (m_ecnt % PRESCALE == 0) ? 1 : 0;
`else
            tick_now = 1;
`endif
            if (tick_now == 1) begin
                m_tc = u ? (m_q == MODULUS - 1) : (m_q == 0);
                if (u) m_q = s ? ((m_q + 1 > MODULUS - 1) ? MODULUS - 1 : m_q + 1) : (m_q + 1) % MODULUS;
                else   m_q = s ? ((m_q - 1 < 0) ? 0 : m_q - 1) : (m_q + MODULUS - 1) % MODULUS;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        #12;
        check_all("reset", 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset mid-count, no clock edge in between
        apply(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        check("preload7.q", int'(q), 7);
        @(negedge clk);
        ld = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

`ifndef UDCNT_PRESCALE_EN
        // Down wrap from 5
        add(1, 5, 0, 0, 0, 5, 0);
        add(0, 0, 1, 0, 0, 4, 0);
        add(0, 0, 1, 0, 0, 3, 0);
        add(0, 0, 1, 0, 0, 2, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 9, 1);
        add(0, 0, 0, 0, 0, 9, 0);
        // Up saturate from 8
        add(1, 8, 0, 1, 1, 8, 0);
        add(0, 0, 1, 1, 1, 9, 0);
        add(0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 1, 1, 1, 9, 1);
        add(0, 0, 0, 1, 1, 9, 0);
        // Load clamps and overrides en; also clears a pending tc
        add(0, 0, 1, 1, 1, 9, 1);
        add(1, 13, 1, 1, 0, 9, 0);
        add(1, 2, 1, 1, 0, 2, 0);
        // Up wrap at 9
        add(1, 9, 0, 1, 0, 9, 0);
        add(0, 0, 1, 1, 0, 0, 1);
        // Down saturate at 0
        add(0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 1, 0, 1, 0, 1);
        // Direction flip with no stall
        add(1, 3, 0, 1, 0, 3, 0);
        add(0, 0, 1, 1, 0, 4, 0);
        add(0, 0, 1, 1, 0, 5, 0);
        add(0, 0, 1, 1, 0, 6, 0);
        add(0, 0, 1, 0, 0, 5, 0);
        add(0, 0, 1, 0, 0, 4, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].ld, tbl[i].d, tbl[i].en, tbl[i].up_dn, tbl[i].sat);
            check_all($sformatf("vec%0d", i), tbl[i].exp_q, tbl[i].exp_tc);
        end
`else
        // Prescaled: q advances once per PRESCALE enabled cycles; en=0 stretches it.
        begin
            int k;
            apply(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
            check_all("ps_load", 0, 1'b0);
            k = 0;
            for (int c = 0; c < 14; c++) begin
                logic e;
                e = !(c == 6 || c == 7);
                apply(1'b0, 4'd0, e, 1'b1, 1'b0);
                if (e) k++;
                check_all($sformatf("ps_c%0d", c), k / PRESCALE, 1'b0);
            end
            check("ps_final.q", int'(q), 3);
        end
`endif

        // Randomised run against the reference model; first cycle loads to sync state.
        m_q = 0; m_ecnt = 0; m_tc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic l, e, u, s;
            logic [3:0] dv;
            l  = (i == 0) || ($urandom_range(0, 9) == 0);
            dv = 4'($urandom_range(0, 15));
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 80 : 20));
            s  = ($urandom_range(0, 2) == 0);
            apply(l, dv, e, u, s);
            model_step(l, int'(dv), e, u, s);
            check_all($sformatf("rnd%0d", i), m_q, m_tc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
